// File: rtl/lamp_monitor.sv
// lamp_monitor: watches the lamp drives of two streets and latches the first
// sequencing fault (conflict, not-one-hot, illegal transition, yellow too
// short, yellow too long). While faulted it produces a flashing-red enable.
// Optional feature: define LAMP_MONITOR_VIOL_CNT_EN to add an 8-bit saturating
// violation-cycle counter on viol_cnt; otherwise viol_cnt is tied to 0.
module lamp_monitor #(
    parameter int MIN_YEL   = 2,
    parameter int MAX_YEL   = 8,
    parameter int FLASH_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       LaG,
    input  logic       LaY,
    input  logic       LaR,
    input  logic       LbG,
    input  logic       LbY,
    input  logic       LbR,
    input  logic       clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       fault_b,
    output logic       flash,
    output logic [7:0] viol_cnt
);

    // yel_cnt must be able to hold MAX_YEL+1
    localparam int YW = $clog2(MAX_YEL + 2);
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    localparam logic [YW-1:0] YEL_MIN = YW'(MIN_YEL);
    localparam logic [YW-1:0] YEL_MAX = YW'(MAX_YEL);
    localparam logic [YW-1:0] YEL_SAT = YW'(MAX_YEL + 1);
    localparam logic [FW-1:0] FLASH_RELOAD = FW'(FLASH_DIV - 1);

    localparam logic [2:0] CODE_NONE     = 3'b000;
    localparam logic [2:0] CODE_CONFLICT = 3'b001;
    localparam logic [2:0] CODE_BAD      = 3'b010;
    localparam logic [2:0] CODE_TRANS    = 3'b011;
    localparam logic [2:0] CODE_Y_SHORT  = 3'b100;
    localparam logic [2:0] CODE_Y_LONG   = 3'b101;

    typedef enum logic [1:0] {
        CLS_G   = 2'd0,
        CLS_Y   = 2'd1,
        CLS_R   = 2'd2,
        CLS_BAD = 2'd3
    } lamp_cls_e;

    function automatic lamp_cls_e classify(input logic g, input logic y, input logic r);
        case ({g, y, r})
            3'b100:  return CLS_G;
            3'b010:  return CLS_Y;
            3'b001:  return CLS_R;
            default: return CLS_BAD;
        endcase
    endfunction

    // Lowest-numbered single-street violation, conflict excluded.
    function automatic logic [2:0] street_code(input lamp_cls_e cur, input lamp_cls_e prev,
                                               input logic pv, input logic [YW-1:0] yc);
        logic [2:0] code;
        code = CODE_NONE;
        if (cur == CLS_BAD)
            code = CODE_BAD;
        else if (pv && ((prev == CLS_G && cur == CLS_R) ||
                        (prev == CLS_Y && cur == CLS_G) ||
                        (prev == CLS_R && cur == CLS_Y)))
            code = CODE_TRANS;
        else if (pv && prev == CLS_Y && cur == CLS_R && yc < YEL_MIN)
            code = CODE_Y_SHORT;
        else if (cur == CLS_Y && yc == YEL_MAX)
            code = CODE_Y_LONG;
        return code;
    endfunction

    // Non-Y clears; a count of 0 means Y is being entered; saturate above MAX_YEL.
    function automatic logic [YW-1:0] yel_next(input lamp_cls_e cur, input logic [YW-1:0] yc);
        if (cur != CLS_Y)
            return '0;
        else if (yc == '0)
            return YW'(1);
        else if (yc == YEL_SAT)
            return yc;
        else
            return yc + YW'(1);
    endfunction

    lamp_cls_e       cls_a, cls_b;
    lamp_cls_e       prev_a_q, prev_a_d, prev_b_q, prev_b_d;
    logic            prev_valid_q, prev_valid_d;
    logic [YW-1:0]   yel_a_q, yel_a_d, yel_b_q, yel_b_d;
    logic            fault_q, fault_d;
    logic [2:0]      code_q, code_d;
    logic            fb_q, fb_d;
    logic            flash_q, flash_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic [2:0]      code_a, code_b, new_code;
    logic            new_b, conflict, viol;

    assign cls_a = classify(LaG, LaY, LaR);
    assign cls_b = classify(LbG, LbY, LbR);

    // Evaluate all checks against the registered history and pick the winner.
    always_comb begin
        code_a   = street_code(cls_a, prev_a_q, prev_valid_q, yel_a_q);
        code_b   = street_code(cls_b, prev_b_q, prev_valid_q, yel_b_q);
        conflict = (cls_a == CLS_G || cls_a == CLS_Y) && (cls_b == CLS_G || cls_b == CLS_Y);
        new_code = CODE_NONE;
        new_b    = 1'b0;
        if (conflict) begin
            new_code = CODE_CONFLICT;
        end else if (code_a != CODE_NONE && (code_b == CODE_NONE || code_a <= code_b)) begin
            new_code = code_a;
        end else if (code_b != CODE_NONE) begin
            new_code = code_b;
            new_b    = 1'b1;
        end
        viol = (new_code != CODE_NONE);
    end

    // Next-state for history, fault latch and flash timer.
    always_comb begin
        prev_a_d     = cls_a;
        prev_b_d     = cls_b;
        prev_valid_d = 1'b1;
        yel_a_d      = yel_next(cls_a, yel_a_q);
        yel_b_d      = yel_next(cls_b, yel_b_q);
        fault_d      = fault_q;
        code_d       = code_q;
        fb_d         = fb_q;
        flash_d      = 1'b0;
        fcnt_d       = FLASH_RELOAD;

        if (viol && (!fault_q || clr)) begin
            fault_d = 1'b1;
            code_d  = new_code;
            fb_d    = new_b;
        end else if (clr) begin
            fault_d = 1'b0;
            code_d  = CODE_NONE;
            fb_d    = 1'b0;
        end

        // Flash phase restarts only when fault rises, not on a clr-and-relatch.
        if (fault_d) begin
            if (!fault_q) begin
                flash_d = 1'b1;
                fcnt_d  = FLASH_RELOAD;
            end else if (fcnt_q == '0) begin
                flash_d = ~flash_q;
                fcnt_d  = FLASH_RELOAD;
            end else begin
                flash_d = flash_q;
                fcnt_d  = fcnt_q - FW'(1);
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_a_q     <= CLS_G;
            prev_b_q     <= CLS_G;
            prev_valid_q <= 1'b0;
            yel_a_q      <= '0;
            yel_b_q      <= '0;
            fault_q      <= 1'b0;
            code_q       <= CODE_NONE;
            fb_q         <= 1'b0;
            flash_q      <= 1'b0;
            fcnt_q       <= '0;
        end else begin
            prev_a_q     <= prev_a_d;
            prev_b_q     <= prev_b_d;
            prev_valid_q <= prev_valid_d;
            yel_a_q      <= yel_a_d;
            yel_b_q      <= yel_b_d;
            fault_q      <= fault_d;
            code_q       <= code_d;
            fb_q         <= fb_d;
            flash_q      <= flash_d;
            fcnt_q       <= fcnt_d;
        end
    end

    assign fault      = fault_q;
    assign fault_code = code_q;
    assign fault_b    = fb_q;
    assign flash      = flash_q;

`ifdef LAMP_MONITOR_VIOL_CNT_EN
    logic [7:0] viol_cnt_q, viol_cnt_d;

    // Saturating count of violation cycles; clr only empties it on a clean cycle.
    always_comb begin
        viol_cnt_d = viol_cnt_q;
        if (viol) begin
            if (viol_cnt_q != 8'hFF)
                viol_cnt_d = viol_cnt_q + 8'd1;
        end else if (clr) begin
            viol_cnt_d = 8'd0;
        end
    end

    // Violation counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            viol_cnt_q <= 8'd0;
        else
            viol_cnt_q <= viol_cnt_d;
    end

    assign viol_cnt = viol_cnt_q;
`else
    assign viol_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_lamp_monitor.sv
// Testbench for lamp_monitor: directed scenarios plus randomized lamp traffic,
// compared every cycle against a behavioural model of the monitoring rules.
module tb_lamp_monitor;

    localparam int MIN_YEL   = 2;
    localparam int MAX_YEL   = 8;
    localparam int FLASH_DIV = 4;
    localparam int G = 0, Y = 1, R = 2;

    logic       clk, reset;
    logic [2:0] in_a, in_b;
    logic       in_clr;
    logic       fault, fault_b, flash;
    logic [2:0] fault_code;
    logic [7:0] viol_cnt;

    int checks = 0;
    int failures = 0;

    lamp_monitor #(.MIN_YEL(MIN_YEL), .MAX_YEL(MAX_YEL), .FLASH_DIV(FLASH_DIV)) dut (
        .clk(clk), .reset(reset),
        .LaG(in_a[2]), .LaY(in_a[1]), .LaR(in_a[0]),
        .LbG(in_b[2]), .LbY(in_b[1]), .LbR(in_b[0]),
        .clr(in_clr),
        .fault(fault), .fault_code(fault_code), .fault_b(fault_b),
        .flash(flash), .viol_cnt(viol_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_prev[2];
    int m_yrun[2];     // consecutive Y edges seen so far on each street
    bit m_pv;
    int m_fault, m_code, m_b, m_rise, m_cyc, m_vcnt;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int cls_of(input logic [2:0] l);
        case (l)
            3'b100:  return G;
            3'b010:  return Y;
            3'b001:  return R;
            default: return 3;
        endcase
    endfunction

    function automatic logic [2:0] lamp(input int c);
        case (c)
            G:       return 3'b100;
            Y:       return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    // Legal progression is G->Y->R->G (i.e. +1 mod 3) or holding.
    function automatic bit street_viol(input int code, input int s, input int cur);
        case (code)
            2: return cur == 3;
            3: return m_pv && m_prev[s] < 3 && cur < 3 && cur != m_prev[s] && cur != (m_prev[s] + 1) % 3;
            4: return m_pv && m_prev[s] == Y && cur == R && m_yrun[s] < MIN_YEL;
            5: return cur == Y && m_yrun[s] == MAX_YEL;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_prev = '{0, 0};
        m_yrun = '{0, 0};
        m_pv = 0; m_fault = 0; m_code = 0; m_b = 0; m_rise = 0; m_cyc = 0; m_vcnt = 0;
    endtask

    task automatic model_edge();
        int cur[2];
        int code, b;
        cur[0] = cls_of(in_a);
        cur[1] = cls_of(in_b);
        code = 0; b = 0;
        if (cur[0] <= Y && cur[1] <= Y) code = 1;
        for (int c = 2; c <= 5 && code == 0; c++)
            for (int s = 0; s < 2 && code == 0; s++)
                if (street_viol(c, s, cur[s])) begin code = c; b = s; end
        m_cyc++;
        if (code != 0 && (m_fault == 0 || in_clr)) begin
            if (m_fault == 0) m_rise = m_cyc;
            m_fault = 1; m_code = code; m_b = b;
        end else if (in_clr) begin
            m_fault = 0; m_code = 0; m_b = 0;
        end
        if (code != 0) m_vcnt = (m_vcnt < 255) ? m_vcnt + 1 : 255;
        else if (in_clr) m_vcnt = 0;
        for (int s = 0; s < 2; s++) begin
            m_yrun[s] = (cur[s] == Y) ? m_yrun[s] + 1 : 0;
            m_prev[s] = cur[s];
        end
        m_pv = 1;
    endtask

    function automatic int exp_vcnt();
`ifdef LAMP_MONITOR_VIOL_CNT_EN
        return m_vcnt;
`else
        return 0;
`endif
    endfunction

    task automatic compare_all();
        int exp_flash;
        exp_flash = m_fault ? ((((m_cyc - m_rise) / FLASH_DIV) % 2) == 0) : 0;
        check("fault", int'(fault), m_fault);
        check("fault_code", int'(fault_code), m_code);
        check("fault_b", int'(fault_b), m_b);
        check("flash", int'(flash), exp_flash);
        check("viol_cnt", int'(viol_cnt), exp_vcnt());
    endtask

    // Drive inputs (called just after a negedge), clock one edge, check at +1.
    task automatic step(input logic [2:0] a, input logic [2:0] b, input logic c);
        in_a = a; in_b = b; in_clr = c;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_fault", int'(fault), 0);
        check("rst_code", int'(fault_code), 0);
        check("rst_b", int'(fault_b), 0);
        check("rst_flash", int'(flash), 0);
        check("rst_vcnt", int'(viol_cnt), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    int a_seq[10] = '{G, G, G, Y, Y, R, R, R, R, R};
    int b_seq[10] = '{R, R, R, R, R, G, G, G, Y, Y};
    int st[2];
    logic [2:0] rl[2];

    initial begin
        reset = 1'b1; in_a = 3'b001; in_b = 3'b001; in_clr = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Legal two-street cycle, twice.
        for (int rep = 0; rep < 2; rep++)
            for (int i = 0; i < 10; i++)
                step(lamp(a_seq[i]), lamp(b_seq[i]), 1'b0);
        check("legal_fault", int'(fault), 0);
        check("legal_flash", int'(flash), 0);

        // Both green -> conflict, then watch flash pattern 1111 0000.
        do_reset();
        step(lamp(G), lamp(G), 1'b0);
        check("conf_code", int'(fault_code), 1);
        check("conf_b", int'(fault_b), 0);
        for (int i = 1; i < 8; i++) begin
            step(lamp(G), lamp(R), 1'b0);
            check("conf_flash_pat", int'(flash), (i < 4) ? 1 : 0);
        end

        // Street B G->R, later conflict keeps 011, clr with clean inputs clears.
        do_reset();
        step(lamp(R), lamp(R), 1'b0);
        step(lamp(R), lamp(G), 1'b0);
        step(lamp(R), lamp(R), 1'b0);
        check("trans_code", int'(fault_code), 3);
        check("trans_b", int'(fault_b), 1);
        step(lamp(G), lamp(G), 1'b0);
        check("trans_hold", int'(fault_code), 3);
        step(lamp(R), lamp(R), 1'b0);
        step(lamp(R), lamp(R), 1'b1);
        check("clr_fault", int'(fault), 0);

        // A yellow for one cycle then red -> yellow too short.
        do_reset();
        step(lamp(R), lamp(R), 1'b0);
        step(lamp(G), lamp(R), 1'b0);
        step(lamp(Y), lamp(R), 1'b0);
        step(lamp(R), lamp(R), 1'b0);
        check("yshort_code", int'(fault_code), 4);
        check("yshort_b", int'(fault_b), 0);

        // A yellow for nine cycles -> yellow too long at the 9th edge.
        do_reset();
        step(lamp(G), lamp(R), 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(lamp(Y), lamp(R), 1'b0);
            if (i == 7) check("ylong_pre", int'(fault), 0);
        end
        check("ylong_code", int'(fault_code), 5);

        // All A lamps off with clr -> relatched as 010.
        step(3'b000, lamp(R), 1'b1);
        check("bad_fault", int'(fault), 1);
        check("bad_code", int'(fault_code), 2);

        // Reset mid-fault; first edge after release shows Y (after R) unflagged.
        #2;
        in_a = lamp(Y); in_b = lamp(R);
        do_reset();
        step(lamp(Y), lamp(R), 1'b0);
        check("post_rst_fault", int'(fault), 0);

        // Long conflict run for the violation counter.
        do_reset();
        for (int i = 0; i < 300; i++) step(lamp(G), lamp(G), 1'b0);
`ifdef LAMP_MONITOR_VIOL_CNT_EN
        check("vcnt_sat", int'(viol_cnt), 255);
`else
        check("vcnt_off", int'(viol_cnt), 0);
`endif
        step(lamp(Y), lamp(G), 1'b0);
        step(lamp(Y), lamp(Y), 1'b0);
        step(lamp(R), lamp(Y), 1'b0);
        step(lamp(R), lamp(R), 1'b1);
        check("vcnt_clr", int'(viol_cnt), 0);
        check("vcnt_clr_fault", int'(fault), 0);

        // Randomized traffic: mostly legal progressions, occasional garbage, random clr.
        do_reset();
        st = '{R, R};
        for (int i = 0; i < 600; i++) begin
            for (int s = 0; s < 2; s++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 6) rl[s] = 3'($urandom_range(0, 7));
                else begin
                    if (r < 35) st[s] = (st[s] + 1) % 3;
                    else if (r < 38) st[s] = $urandom_range(0, 2);
                    rl[s] = lamp(st[s]);
                end
            end
            step(rl[0], rl[1], ($urandom_range(0, 7) == 0));
            if (i == 300) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lamp_monitor.md
LAMP_MONITOR -- requirements
Module: lamp_monitor

Interface
REQ-001 Parameter MIN_YEL, default 2: minimum legal consecutive yellow cycles per street.
REQ-002 Parameter MAX_YEL, default 8: maximum legal consecutive yellow cycles per street.
REQ-003 Parameter FLASH_DIV, default 4: cycles per half-period of the flash output.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Ports LaG, LaY, LaR  input  1 each  street-A green/yellow/red lamp drive being monitored.
REQ-007 Ports LbG, LbY, LbR  input  1 each  street-B green/yellow/red lamp drive being monitored.
REQ-008 Port clr  input  1  synchronous fault clear.
REQ-009 Port fault  output  1  latched fault flag.
REQ-010 Port fault_code  output  3  code of the first latched fault.
REQ-011 Port fault_b  output  1  0 = street A (or conflict), 1 = street B caused the fault.
REQ-012 Port flash  output  1  flashing-red enable for the lamp driver while faulted.
REQ-013 Port viol_cnt  output  8  violation-cycle count (see Configuration).

Function
REQ-014 Each street's lamp triple SHALL be classified G, Y, R (exactly one lamp lit) or BAD (zero or more than one lit).
REQ-015 Per street, the block SHALL register prev lamp class, a prev_valid flag, and a yel_cnt counter wide enough for MAX_YEL+1.
REQ-016 Checks SHALL be evaluated combinationally from current inputs against registered state; the result SHALL be registered, giving fault high after the first rising edge at which a violation is present (1-cycle latency).
REQ-017 Code 3'b001 conflict: both streets simultaneously in G or Y.
REQ-018 Code 3'b010 lamp-not-one-hot: either street classified BAD.
REQ-019 Code 3'b011 illegal transition: prev_valid and prev->current is G->R, Y->G or R->Y; the legal transitions are G->Y, Y->R, R->G and hold.
REQ-020 Code 3'b100 yellow too short: prev Y, current R, and yel_cnt < MIN_YEL.
REQ-021 Code 3'b101 yellow too long: current Y and yel_cnt == MAX_YEL.
REQ-022 yel_cnt SHALL load 1 on entering Y, increment while Y holds (saturating), and clear on any non-Y class.
REQ-023 With several simultaneous violations, the lowest code SHALL win; for equal codes, street A SHALL win.
REQ-024 fault_b SHALL be 0 for codes 001 and 010-when-A, and otherwise SHALL indicate the offending street.
REQ-025 Once fault=1, fault_code and fault_b SHALL hold the first fault until clr, even if new violations occur.
REQ-026 When clr=1, fault SHALL clear at the edge, unless a violation is present in the same cycle, in which case fault stays 1 with the new code.
REQ-027 prev_valid SHALL be 0 after reset and set after the first sampled edge; transition and yellow-short checks SHALL be suppressed while prev_valid=0.
REQ-028 While fault=1, flash SHALL be 1 for FLASH_DIV cycles, then 0 for FLASH_DIV cycles, repeating from the edge fault rises; while fault=0, flash SHALL be 0.

Reset
REQ-029 Reset SHALL act asynchronously; while asserted, fault, fault_code, fault_b, flash, viol_cnt, yel_cnt and prev_valid SHALL all be 0.
REQ-030 Reset asserted mid-fault or mid-yellow SHALL discard all history; monitoring SHALL restart per REQ-027.

Configuration
REQ-031 Macro LAMP_MONITOR_VIOL_CNT_EN defined: viol_cnt SHALL increment on every edge at which any violation is present (latched or not), saturate at 255, and clear on clr only when no violation is present.
REQ-032 Macro LAMP_MONITOR_VIOL_CNT_EN undefined: viol_cnt SHALL be constant 0 and no counter logic SHALL exist; all other behaviour SHALL be unchanged.

Verification
REQ-033 Legal cycle (A: G x3, Y x2, R x5; B: R x5, G x3, Y x2, repeat twice) -> fault stays 0, flash stays 0.
REQ-034 LaG=1 and LbG=1 at one edge -> fault=1, fault_code=001, fault_b=0 after that edge; flash=1 for 4 cycles, then 0 for 4 cycles.
REQ-035 Street B goes G->R directly -> fault_code=011, fault_b=1; a later conflict leaves the code at 011; clr with clean inputs -> fault=0 next edge.
REQ-036 Street A yellow for 1 cycle, then R -> code 100; separately, A yellow for 9 cycles -> code 101 latched at the 9th yellow edge.
REQ-037 All A lamps off while clr=1 -> fault stays 1 with code 010; reset pulsed low mid-fault -> all outputs 0 immediately; after release, an R->Y input at the first edge is not flagged.
REQ-038 With the macro defined, 300 consecutive conflict cycles -> viol_cnt=255; with the macro undefined -> viol_cnt=0.
